prf_read_arbiter: RTL and testbench

- Read-side counterpart of the physical-regfile write-port funnel.
- Accepts up to NUM_RD independent read requests per cycle.
- Serves them through the regfile's 2 synchronous read ports: round-robin arbitration, same-address coalescing, registered return path.
- Sits between the issue/operand-fetch stage and the physical regfile; requesters hold a request until granted.

---
 rtl/rcu_pkg.sv | 24 ++
 rtl/prf_rr_pick.sv | 57 +++++
 rtl/prf_read_arbiter.sv | 174 +++++++++++++++++
 tb/tb_prf_read_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcu_pkg.sv
// ----------------------------------------------------------------------------
// rcu_pkg
// Shared constants for the register-file access blocks of the rename/commit
// unit: default register index / data widths, the number of physical-regfile
// read ports, and a small one-hot decode helper.
// ----------------------------------------------------------------------------
package rcu_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 6;   // physical register index width
    localparam int DEF_REG_DATA_WIDTH = 64;  // register data width
    localparam int PRF_RD_PORTS       = 2;   // synchronous read ports on the regfile
    localparam int MAX_RD             = 8;   // largest supported requester count

    // Index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic int onehot_to_idx(input logic [MAX_RD-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_RD; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/prf_rr_pick.sv
// ----------------------------------------------------------------------------
// prf_rr_pick
// Combinational round-robin picker. Scans N request bits starting at ptr_i
// and wrapping modulo N, returning the first and second set bits as one-hot
// vectors plus found flags.
//
// The second pick is taken from its own request vector (second_req_i) so the
// caller can remove candidates that must not win the second slot (e.g. those
// coalesced onto the first pick). The first pick is always excluded from it.
//
// Ports:
//   first_req_i     candidates for the first pick
//   second_req_i    candidates for the second pick
//   ptr_i           highest-priority index
//   first_oh_o      one-hot first pick,  first_found_o  any first pick
//   second_oh_o     one-hot second pick, second_found_o any second pick
// ----------------------------------------------------------------------------
module prf_rr_pick
    import rcu_pkg::*;
#(
    parameter int N     = 6,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     first_req_i,
    input  logic [N-1:0]     second_req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     first_oh_o,
    output logic             first_found_o,
    output logic [N-1:0]     second_oh_o,
    output logic             second_found_o
);

    // Two linear passes replace a rotate: the first pass only accepts indices
    // at or above the pointer; if it found nothing, the second pass takes the
    // lowest set index, which is then necessarily below the pointer.
    function automatic logic [N-1:0] pick_from(input logic [N-1:0]     v,
                                               input logic [PTR_W-1:0] p);
        logic [N-1:0] oh;
        oh = '0;
        for (int i = 0; i < N; i++) begin
            if (oh == '0 && i >= int'(p) && v[i]) oh[i] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (oh == '0 && v[i]) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    logic [N-1:0] second_cand;

    assign first_oh_o     = pick_from(first_req_i, ptr_i);
    assign first_found_o  = |first_oh_o;
    assign second_cand    = second_req_i & ~first_oh_o;
    assign second_oh_o    = pick_from(second_cand, ptr_i);
    assign second_found_o = |second_oh_o;

endmodule

// File: rtl/prf_read_arbiter.sv
// ----------------------------------------------------------------------------
// prf_read_arbiter
// Funnels up to NUM_RD operand read requests per cycle onto the physical
// regfile's two synchronous read ports. Round-robin arbitration picks a first
// requester and a second requester with a different address; every requester
// sharing either address is coalesced onto that port and granted together.
// Read data returns one cycle after the grant.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rd_req[NUM_RD]                 per-requester request, held until granted
//   rd_address[NUM_RD*AW]          packed addresses, requester i at [i*AW +: AW]
//   rd_gnt[NUM_RD]                 combinational grant in the request cycle
//   rd_rvalid[NUM_RD]              one-cycle data-valid, cycle after grant
//   rd_data[NUM_RD*DW]             packed read data, held when not valid
//   prf_rd_first_*                 regfile read port 0 (en, address, data)
//   prf_rd_second_*                regfile read port 1 (en, address, data)
//   flush                          drop the responses of this cycle's grants
//
// The regfile's read data is valid (from its own output flops) in the cycle
// after the enable. Each port keeps a registered owner mask for that cycle,
// which steers the port data to the owning slices; rd_data_q keeps every
// slice stable between responses.
// ----------------------------------------------------------------------------
module prf_read_arbiter
    import rcu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
    parameter int NUM_RD         = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD-1:0]                  rd_req,
    input  logic [NUM_RD*REG_ADDR_WIDTH-1:0]   rd_address,
    output logic [NUM_RD-1:0]                  rd_gnt,
    output logic [NUM_RD-1:0]                  rd_rvalid,
    output logic [NUM_RD*REG_DATA_WIDTH-1:0]   rd_data,
    output logic                               prf_rd_first_en,
    output logic [REG_ADDR_WIDTH-1:0]          prf_rd_first_address,
    input  logic [REG_DATA_WIDTH-1:0]          prf_rd_first_data,
    output logic                               prf_rd_second_en,
    output logic [REG_ADDR_WIDTH-1:0]          prf_rd_second_address,
    input  logic [REG_DATA_WIDTH-1:0]          prf_rd_second_data,
    input  logic                               flush
);

    localparam int AW    = REG_ADDR_WIDTH;
    localparam int DW    = REG_DATA_WIDTH;
    localparam int PTR_W = $clog2(NUM_RD);

    // Pointer value just past the requester named by a one-hot vector.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [NUM_RD-1:0] oh);
        int idx;
        idx = onehot_to_idx(MAX_RD'(oh));
        return (idx == NUM_RD - 1) ? '0 : PTR_W'(idx + 1);
    endfunction

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_RD-1:0] first_oh, second_oh, second_req;
    logic              first_found, second_found;
    logic [AW-1:0]     addr_f, addr_s;
    logic [NUM_RD-1:0] match_f, match_s;

    // Per-port owner masks: combinational for the request cycle, registered
    // for the data-return cycle.
    logic [NUM_RD-1:0] own_d   [PRF_RD_PORTS];
    logic [NUM_RD-1:0] owner_q [PRF_RD_PORTS];
    logic              valid_q [PRF_RD_PORTS];

    logic [NUM_RD*DW-1:0] rd_data_q;

    prf_rr_pick #(
        .N     (NUM_RD),
        .PTR_W (PTR_W)
    ) u_pick (
        .first_req_i    (rd_req),
        .second_req_i   (second_req),
        .ptr_i          (rr_ptr_q),
        .first_oh_o     (first_oh),
        .first_found_o  (first_found),
        .second_oh_o    (second_oh),
        .second_found_o (second_found)
    );

    // First port: its address and every requester coalesced onto it. Anyone
    // sharing that address is removed from the second-port candidates. Kept
    // apart from the second-port block so the two never form a false loop.
    // NOTE: every variable written in an always_comb gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        addr_f  = '0;
        match_f = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (first_oh[i]) addr_f = rd_address[i*AW +: AW];
        end
        for (int i = 0; i < NUM_RD; i++) begin
            match_f[i] = first_found && rd_req[i] && (rd_address[i*AW +: AW] == addr_f);
        end
        second_req = rd_req & ~match_f;
    end

    // Second port: its address and every requester coalesced onto it.
    always_comb begin
        addr_s  = '0;
        match_s = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (second_oh[i]) addr_s = rd_address[i*AW +: AW];
        end
        for (int i = 0; i < NUM_RD; i++) begin
            match_s[i] = second_found && rd_req[i] && (rd_address[i*AW +: AW] == addr_s);
        end
    end

    // Grants, port drive and pointer advance. Nothing is granted in reset.
    always_comb begin
        own_d[0] = rst ? '0 : match_f;
        own_d[1] = rst ? '0 : match_s;

        rd_gnt                = own_d[0] | own_d[1];
        prf_rd_first_en       = |own_d[0];
        prf_rd_first_address  = prf_rd_first_en ? addr_f : '0;
        prf_rd_second_en      = |own_d[1];
        prf_rd_second_address = prf_rd_second_en ? addr_s : '0;

        // The pointer moves past the last index picked in priority order,
        // not past coalesced followers, so each wins the port in its turn.
        rr_ptr_d = rr_ptr_q;
        if (first_found) begin
            rr_ptr_d = second_found ? ptr_after(second_oh) : ptr_after(first_oh);
        end
    end

    // Return path: steer each port's data to the slices it owns.
    always_comb begin
        rd_rvalid = '0;
        rd_data   = rd_data_q;
        for (int i = 0; i < NUM_RD; i++) begin
            if (valid_q[0] && owner_q[0][i]) begin
                rd_rvalid[i]          = 1'b1;
                rd_data[i*DW +: DW]   = prf_rd_first_data;
            end else if (valid_q[1] && owner_q[1][i]) begin
                rd_rvalid[i]          = 1'b1;
                rd_data[i*DW +: DW]   = prf_rd_second_data;
            end
        end
        // Responses still in flight when reset arrives are dropped at once.
        if (rst) rd_rvalid = '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            // NOTE: the data-hold register is reset like any control flop
            // because requesters may read a slice before its first response.
            rd_data_q <= '0;
            for (int p = 0; p < PRF_RD_PORTS; p++) begin
                valid_q[p] <= 1'b0;
                owner_q[p] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rd_data_q <= rd_data;
            for (int p = 0; p < PRF_RD_PORTS; p++) begin
                // A flush kills only the grants issued in its own cycle.
                valid_q[p] <= (|own_d[p]) && !flush;
                owner_q[p] <= flush ? '0 : own_d[p];
            end
        end
    end

endmodule

// File: tb/tb_prf_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_prf_read_arbiter
// Directed vector table for the documented corner cases, followed by random
// held-request traffic, all compared against a reference model that applies
// the arbitration rules directly: scan order from the pointer, address
// equality for coalescing, and a regfile memory for expected read data.
// ----------------------------------------------------------------------------
module tb_prf_read_arbiter;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int N  = 6;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic [N-1:0]      rd_req, rd_gnt, rd_rvalid;
    logic [N*AW-1:0]   rd_address;
    logic [N*DW-1:0]   rd_data;
    logic              prf_rd_first_en, prf_rd_second_en;
    logic [AW-1:0]     prf_rd_first_address, prf_rd_second_address;
    logic [DW-1:0]     prf_rd_first_data, prf_rd_second_data;

    always #5 clk = ~clk;

    prf_read_arbiter #(
        .REG_ADDR_WIDTH (AW),
        .REG_DATA_WIDTH (DW),
        .NUM_RD         (N)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rd_req                (rd_req),
        .rd_address            (rd_address),
        .rd_gnt                (rd_gnt),
        .rd_rvalid             (rd_rvalid),
        .rd_data               (rd_data),
        .prf_rd_first_en       (prf_rd_first_en),
        .prf_rd_first_address  (prf_rd_first_address),
        .prf_rd_first_data     (prf_rd_first_data),
        .prf_rd_second_en      (prf_rd_second_en),
        .prf_rd_second_address (prf_rd_second_address),
        .prf_rd_second_data    (prf_rd_second_data),
        .flush                 (flush)
    );

    // Regfile model: synchronous read, data valid the cycle after enable;
    // idle ports return a recognisable junk pattern.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        prf_rd_first_data  <= prf_rd_first_en  ? mem[prf_rd_first_address]  : 64'hBAD0_BAD0_BAD0_BAD0;
        prf_rd_second_data <= prf_rd_second_en ? mem[prf_rd_second_address] : 64'hDEAD_DEAD_DEAD_DEAD;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return rd_address[i*AW +: AW];
    endfunction

    // ---------------- reference model state ----------------
    int            m_ptr   = 0;
    bit            m_known = 1'b0;
    logic [N-1:0]  m_pend  = '0;
    logic [AW-1:0] m_paddr [N];
    logic [DW-1:0] m_data  [N];

    // Compares the current cycle against the model, then advances the model
    // across the coming clock edge. Returns the expected grant vector.
    task automatic model_check(output logic [N-1:0] g);
        int f, s, idx;
        logic [AW-1:0] fa, sa;
        logic [DW-1:0] exp_d;
        f = -1; s = -1; g = '0; fa = '0; sa = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (rd_req[idx] && f < 0) f = idx;
            end
            if (f >= 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (rd_req[idx] && s < 0 && addr_of(idx) != addr_of(f)) s = idx;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rd_req[i] && f >= 0 && addr_of(i) == addr_of(f)) g[i] = 1'b1;
                if (rd_req[i] && s >= 0 && addr_of(i) == addr_of(s)) g[i] = 1'b1;
            end
            if (f >= 0) fa = addr_of(f);
            if (s >= 0) sa = addr_of(s);
        end
        check("gnt",         rd_gnt,                g);
        check("first_en",    prf_rd_first_en,       (f >= 0));
        check("first_addr",  prf_rd_first_address,  fa);
        check("second_en",   prf_rd_second_en,      (s >= 0));
        check("second_addr", prf_rd_second_address, sa);
        if (m_known) check("rr_ptr", dut.rr_ptr_q, m_ptr);
        if (!rst && m_known) begin
            check("rvalid", rd_rvalid, m_pend);
            for (int i = 0; i < N; i++) begin
                exp_d = m_pend[i] ? mem[m_paddr[i]] : m_data[i];
                check($sformatf("rd_data[%0d]", i), rd_data[i*DW +: DW], exp_d);
                m_data[i] = exp_d;
            end
        end
        if (rst) begin
            m_ptr   = 0;
            m_pend  = '0;
            m_known = 1'b1;
            for (int i = 0; i < N; i++) m_data[i] = '0;
        end else begin
            m_pend = flush ? '0 : g;
            for (int i = 0; i < N; i++) m_paddr[i] = addr_of(i);
            if (f >= 0) m_ptr = ((s >= 0 ? s : f) + 1) % N;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic          flush;
        logic [N-1:0]  req;
        logic [N*AW-1:0] addr;
        logic [N-1:0]  gnt;
        logic          fen;
        logic [AW-1:0] fa;
        logic          sen;
        logic [AW-1:0] sa;
        logic          chk_rv;
        logic [N-1:0]  rv;
    } vec_t;

    function automatic logic [N*AW-1:0] pk(input int a0, a1, a2, a3, a4, a5);
        return {AW'(a5), AW'(a4), AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic vec_t mk(input logic r, fl, input logic [N-1:0] rq,
                                input logic [N*AW-1:0] ad, input logic [N-1:0] gn,
                                input logic fe, input int fa, input logic se, input int sa,
                                input logic cr, input logic [N-1:0] rv);
        vec_t v;
        v.rst = r; v.flush = fl; v.req = rq; v.addr = ad; v.gnt = gn;
        v.fen = fe; v.fa = AW'(fa); v.sen = se; v.sa = AW'(sa);
        v.chk_rv = cr; v.rv = rv;
        return v;
    endfunction

    task automatic drive(input logic r, input logic fl, input logic [N-1:0] rq,
                         input logic [N*AW-1:0] ad);
        rst = r; flush = fl; rd_req = rq; rd_address = ad;
    endtask

    localparam int NV = 23;
    vec_t tbl [NV];

    logic [N-1:0]  g_exp;
    logic [N-1:0]  held;
    logic [AW-1:0] raddr [N];
    logic [N*AW-1:0] seq_addr, all7;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
        mem[3] = 64'hA;
        mem[9] = 64'hB;
        mem[7] = 64'h55;
        for (int i = 0; i < N; i++) begin
            m_data[i]  = '0;
            m_paddr[i] = '0;
        end
        seq_addr = pk(10, 11, 12, 13, 14, 15);
        all7     = pk(7, 7, 7, 7, 7, 7);

        //               rst flush req        addr                 gnt       fen fa sen sa chkrv rv
        tbl[0]  = mk(1, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  0, 6'b000000);
        tbl[1]  = mk(1, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  0, 6'b000000);
        tbl[2]  = mk(0, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  1, 6'b000000);
        tbl[3]  = mk(0, 0, 6'b000101, pk(3, 0, 9, 0, 0, 0), 6'b000101, 1, 3,  1, 9,  1, 6'b000000);
        tbl[4]  = mk(0, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  1, 6'b000101);
        tbl[5]  = mk(0, 0, 6'b100000, pk(0, 0, 0, 0, 0, 15),6'b100000, 1, 15, 0, 0,  1, 6'b000000);
        tbl[6]  = mk(0, 0, 6'b111111, seq_addr,             6'b000011, 1, 10, 1, 11, 1, 6'b100000);
        tbl[7]  = mk(0, 0, 6'b111111, seq_addr,             6'b001100, 1, 12, 1, 13, 1, 6'b000011);
        tbl[8]  = mk(0, 0, 6'b111111, seq_addr,             6'b110000, 1, 14, 1, 15, 1, 6'b001100);
        tbl[9]  = mk(0, 0, 6'b111111, all7,                 6'b111111, 1, 7,  0, 0,  1, 6'b110000);
        tbl[10] = mk(0, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  1, 6'b111111);
        tbl[11] = mk(0, 1, 6'b000010, pk(0, 20, 0, 0, 0, 0),6'b000010, 1, 20, 0, 0,  1, 6'b000000);
        tbl[12] = mk(0, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  1, 6'b000000);
        tbl[13] = mk(0, 0, 6'b000010, pk(0, 21, 0, 0, 0, 0),6'b000010, 1, 21, 0, 0,  1, 6'b000000);
        tbl[14] = mk(0, 1, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  1, 6'b000010);
        tbl[15] = mk(0, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  1, 6'b000000);
        tbl[16] = mk(0, 0, 6'b110000, pk(0, 0, 0, 0, 30, 31),6'b110000,1, 30, 1, 31, 1, 6'b000000);
        tbl[17] = mk(1, 0, 6'b111111, seq_addr,             6'b000000, 0, 0,  0, 0,  0, 6'b000000);
        tbl[18] = mk(0, 0, 6'b001010, pk(0, 40, 0, 41, 0, 0),6'b001010,1, 40, 1, 41, 1, 6'b000000);
        tbl[19] = mk(0, 0, 6'b000100, pk(0, 0, 1, 0, 0, 0), 6'b000100, 1, 1,  0, 0,  1, 6'b001010);
        tbl[20] = mk(1, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  0, 6'b000000);
        tbl[21] = mk(0, 0, 6'b100001, pk(2, 0, 0, 0, 0, 3), 6'b100001, 1, 2,  1, 3,  1, 6'b000000);
        tbl[22] = mk(0, 0, 6'b000000, '0,                   6'b000000, 0, 0,  0, 0,  1, 6'b100001);

        drive(1'b1, 1'b0, '0, '0);
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].rst, tbl[k].flush, tbl[k].req, tbl[k].addr);
            #2;
            check($sformatf("row%0d gnt", k),         rd_gnt,                tbl[k].gnt);
            check($sformatf("row%0d first_en", k),    prf_rd_first_en,       tbl[k].fen);
            check($sformatf("row%0d first_addr", k),  prf_rd_first_address,  tbl[k].fa);
            check($sformatf("row%0d second_en", k),   prf_rd_second_en,      tbl[k].sen);
            check($sformatf("row%0d second_addr", k), prf_rd_second_address, tbl[k].sa);
            if (tbl[k].chk_rv) check($sformatf("row%0d rvalid", k), rd_rvalid, tbl[k].rv);
            model_check(g_exp);
            @(posedge clk); #1;
        end

        // Explicit data spot checks for the two-distinct and coalesce rows
        // are covered by the model; re-run the coalesce case and check 0x55.
        drive(1'b0, 1'b0, 6'b111111, all7);
        #2;
        model_check(g_exp);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        #2;
        for (int i = 0; i < N; i++) begin
            check($sformatf("coalesce data[%0d]", i), rd_data[i*DW +: DW], 64'h55);
        end
        model_check(g_exp);
        @(posedge clk); #1;

        // ---------------- random held-request traffic ----------------
        held = '0;
        for (int i = 0; i < N; i++) raddr[i] = '0;
        for (int c = 0; c < 600; c++) begin
            logic [N*AW-1:0] ad;
            for (int i = 0; i < N; i++) begin
                if (!held[i] && $urandom_range(0, 2) != 0) begin
                    held[i]  = 1'b1;
                    raddr[i] = AW'($urandom_range(0, 7));
                end
            end
            for (int i = 0; i < N; i++) ad[i*AW +: AW] = raddr[i];
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), held, ad);
            #2;
            model_check(g_exp);
            held = held & ~g_exp;
            @(posedge clk); #1;
        end

        drive(1'b0, 1'b0, '0, '0);
        for (int c = 0; c < 2; c++) begin
            #2;
            model_check(g_exp);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
